// File: rtl/instr_fetch_queue.sv
// Dual-issue fetch queue: circular buffer, push->out_valid in 1 cycle, in_ready low when fewer than 2 slots free.
// Define IFQ_PERF_CNT_EN to build the empty-cycle counter; otherwise empty_cycles is tied to 0.
module instr_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [1:0]  in_valid,
  input  logic [31:0] in_pc0,
  input  logic [31:0] in_pc1,
  input  logic [31:0] in_instr0,
  input  logic [31:0] in_instr1,
  output logic        in_ready,
  output logic [1:0]  out_valid,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_instr0,
  output logic [31:0] out_instr1,
  input  logic [1:0]  issue_count,
  output logic [31:0] empty_cycles
);

  if (PTR_W != $clog2(DEPTH) || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("instr_fetch_queue: DEPTH must be a power of two >= 4 and PTR_W = log2(DEPTH)");
  end

  localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W+1)'(DEPTH - 2);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       push_n, issue_n, pop_n;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  always_comb begin
    in_ready = (count_q <= PUSH_LIMIT);

    push_n = 2'd0;
    if (in_ready && !flush) begin
      case (in_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end

    // Pops are bounded by the pre-push count, so same-cycle pushes are never consumed.
    issue_n = (issue_count == 2'd3) ? 2'd2 : issue_count;
    pop_n   = issue_n;
    if ({{(PTR_W-1){1'b0}}, issue_n} > count_q) pop_n = count_q[1:0];

    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (push_n != 2'd0) begin
        pc_q[tail_q]    <= in_pc0;
        instr_q[tail_q] <= in_instr0;
      end
      if (push_n == 2'd2) begin
        pc_q[tail_p1]    <= in_pc1;
        instr_q[tail_p1] <= in_instr1;
      end
    end
  end

  assign out_valid  = {(count_q >= (PTR_W+1)'(2)), (count_q != '0)};
  assign out_pc0    = pc_q[head_q];
  assign out_pc1    = pc_q[head_p1];
  assign out_instr0 = instr_q[head_q];
  assign out_instr1 = instr_q[head_p1];

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] empty_cycles_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      empty_cycles_q <= '0;
    end else if (count_q == '0 && empty_cycles_q != 32'hFFFF_FFFF) begin
      empty_cycles_q <= empty_cycles_q + 32'd1;
    end
  end

  assign empty_cycles = empty_cycles_q;
`else
  assign empty_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: vector table plus reset/perf-counter sequences.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_pc0, in_pc1, in_instr0, in_instr1;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [31:0] out_pc0, out_pc1, out_instr0, out_instr1;
  logic [1:0]  issue_count;
  logic [31:0] empty_cycles;

  int checks   = 0;
  int failures = 0;

`ifdef IFQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  instr_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc0       (in_pc0),
    .in_pc1       (in_pc1),
    .in_instr0    (in_instr0),
    .in_instr1    (in_instr1),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc0      (out_pc0),
    .out_pc1      (out_pc1),
    .out_instr0   (out_instr0),
    .out_instr1   (out_instr1),
    .issue_count  (issue_count),
    .empty_cycles (empty_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [1:0]  iv;
    logic [31:0] pc0, pc1, i0, i1;
    logic [1:0]  ic;
    logic [1:0]  ov;
    logic        rdy;
    logic [31:0] opc0, opc1, oi0, oi1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic [1:0] iv,
                              input logic [31:0] pc0, input logic [31:0] pc1,
                              input logic [31:0] i0, input logic [31:0] i1,
                              input logic [1:0] ic, input logic [1:0] ov, input logic rdy,
                              input logic [31:0] opc0, input logic [31:0] opc1,
                              input logic [31:0] oi0, input logic [31:0] oi1);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc0 = pc0; v.pc1 = pc1; v.i0 = i0; v.i1 = i1; v.ic = ic;
    v.ov = ov; v.rdy = rdy; v.opc0 = opc0; v.opc1 = opc1; v.oi0 = oi0; v.oi1 = oi1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [1:0] iv, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] ic);
    flush = fl; in_valid = iv; in_pc0 = pc0; in_pc1 = pc1;
    in_instr0 = i0; in_instr1 = i1; issue_count = ic;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ov"},   {30'd0, out_valid}, 32'd0);
    chk({tag, "_pc0"},  out_pc0,    32'd0);
    chk({tag, "_pc1"},  out_pc1,    32'd0);
    chk({tag, "_i0"},   out_instr0, 32'd0);
    chk({tag, "_i1"},   out_instr1, 32'd0);
    chk({tag, "_rdy"},  {31'd0, in_ready}, 32'd1);
    chk({tag, "_perf"}, empty_cycles, 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);

    //        fl iv     pc0           pc1           i0            i1            ic    ov     rdy   opc0          opc1          oi0           oi1
    vecs.push_back(mk(0, 2'b11, 32'h1000, 32'h1004, 32'h2401_0001, 32'h2402_0002, 2'd0, 2'b11, 1, 32'h1000, 32'h1004, 32'h2401_0001, 32'h2402_0002));
    vecs.push_back(mk(0, 2'b11, 32'h1008, 32'h100C, 32'h2400_0003, 32'h2400_0004, 2'd0, 2'b11, 1, 32'h1000, 32'h1004, 32'h2401_0001, 32'h2402_0002));
    vecs.push_back(mk(0, 2'b11, 32'h1010, 32'h1014, 32'h2400_0005, 32'h2400_0006, 2'd0, 2'b11, 1, 32'h1000, 32'h1004, 32'h2401_0001, 32'h2402_0002));
    vecs.push_back(mk(0, 2'b11, 32'h1018, 32'h101C, 32'h2400_0007, 32'h2400_0008, 2'd0, 2'b11, 0, 32'h1000, 32'h1004, 32'h2401_0001, 32'h2402_0002));
    vecs.push_back(mk(0, 2'b11, 32'h2000, 32'h2004, 32'h2400_0F01, 32'h2400_0F02, 2'd0, 2'b11, 0, 32'h1000, 32'h1004, 32'h2401_0001, 32'h2402_0002));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd2, 2'b11, 1, 32'h1008, 32'h100C, 32'h2400_0003, 32'h2400_0004));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd3, 2'b11, 1, 32'h1010, 32'h1014, 32'h2400_0005, 32'h2400_0006));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd1, 2'b11, 1, 32'h1014, 32'h1018, 32'h2400_0006, 32'h2400_0007));
    vecs.push_back(mk(0, 2'b11, 32'h1020, 32'h1024, 32'h2400_0009, 32'h2400_000A, 2'd2, 2'b11, 1, 32'h101C, 32'h1020, 32'h2400_0008, 32'h2400_0009));
    vecs.push_back(mk(0, 2'b11, 32'h1028, 32'h102C, 32'h2400_000B, 32'h2400_000C, 2'd2, 2'b11, 1, 32'h1024, 32'h1028, 32'h2400_000A, 32'h2400_000B));
    vecs.push_back(mk(0, 2'b11, 32'h1030, 32'h1034, 32'h2400_000D, 32'h2400_000E, 2'd2, 2'b11, 1, 32'h102C, 32'h1030, 32'h2400_000C, 32'h2400_000D));
    vecs.push_back(mk(0, 2'b11, 32'h1038, 32'h103C, 32'h2400_000F, 32'h2400_0010, 2'd2, 2'b11, 1, 32'h1034, 32'h1038, 32'h2400_000E, 32'h2400_000F));
    vecs.push_back(mk(0, 2'b01, 32'h1040, 32'h2222, 32'h2400_0011, 32'hDEAD_BEEF, 2'd0, 2'b11, 1, 32'h1034, 32'h1038, 32'h2400_000E, 32'h2400_000F));
    vecs.push_back(mk(0, 2'b11, 32'h1044, 32'h1048, 32'h2400_0012, 32'h2400_0013, 2'd2, 2'b11, 1, 32'h103C, 32'h1040, 32'h2400_0010, 32'h2400_0011));
    vecs.push_back(mk(0, 2'b11, 32'h104C, 32'h1050, 32'h2400_0014, 32'h2400_0015, 2'd2, 2'b11, 1, 32'h1044, 32'h1048, 32'h2400_0012, 32'h2400_0013));
    vecs.push_back(mk(0, 2'b11, 32'h1054, 32'h1058, 32'h2400_0016, 32'h2400_0017, 2'd2, 2'b11, 1, 32'h104C, 32'h1050, 32'h2400_0014, 32'h2400_0015));
    vecs.push_back(mk(0, 2'b11, 32'h105C, 32'h1060, 32'h2400_0018, 32'h2400_0019, 2'd2, 2'b11, 1, 32'h1054, 32'h1058, 32'h2400_0016, 32'h2400_0017));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd2, 2'b11, 1, 32'h105C, 32'h1060, 32'h2400_0018, 32'h2400_0019));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd1, 2'b01, 1, 32'h1060, 32'h1044, 32'h2400_0019, 32'h2400_0012));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd2, 2'b00, 1, 32'h1044, 32'h1048, 32'h2400_0012, 32'h2400_0013));
    vecs.push_back(mk(0, 2'b10, 32'h3000, 32'h3004, 32'h2400_0AAA, 32'h2400_0BBB, 2'd0, 2'b00, 1, 32'h1044, 32'h1048, 32'h2400_0012, 32'h2400_0013));
    vecs.push_back(mk(0, 2'b00, 32'h0,    32'h0,    32'h0,         32'h0,         2'd3, 2'b00, 1, 32'h1044, 32'h1048, 32'h2400_0012, 32'h2400_0013));
    vecs.push_back(mk(0, 2'b11, 32'h4000, 32'h4004, 32'h2400_0021, 32'h2400_0022, 2'd0, 2'b11, 1, 32'h4000, 32'h4004, 32'h2400_0021, 32'h2400_0022));
    vecs.push_back(mk(0, 2'b11, 32'h4008, 32'h400C, 32'h2400_0023, 32'h2400_0024, 2'd0, 2'b11, 1, 32'h4000, 32'h4004, 32'h2400_0021, 32'h2400_0022));
    vecs.push_back(mk(0, 2'b01, 32'h4010, 32'h0,    32'h2400_0025, 32'h0,         2'd0, 2'b11, 1, 32'h4000, 32'h4004, 32'h2400_0021, 32'h2400_0022));
    vecs.push_back(mk(1, 2'b11, 32'h5000, 32'h5004, 32'h2400_0026, 32'h2400_0027, 2'd1, 2'b00, 1, 32'h1060, 32'h4000, 32'h2400_0019, 32'h2400_0021));
    vecs.push_back(mk(0, 2'b11, 32'h6000, 32'h6004, 32'h2400_0028, 32'h2400_0029, 2'd0, 2'b11, 1, 32'h6000, 32'h6004, 32'h2400_0028, 32'h2400_0029));

    // Reset state, sampled before any clock edge.
    #3;
    chk_reset_outputs("rst_async");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_reset_outputs("rst_release");

    // Ten idle edges with an empty queue, then a flush that must not clear the counter.
    repeat (10) @(posedge clk);
    #1;
    chk("perf_idle10", empty_cycles, PERF ? 32'd10 : 32'd0);
    @(negedge clk);
    drive(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    @(posedge clk);
    #1;
    chk("perf_after_flush", empty_cycles, PERF ? 32'd11 : 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc0, vecs[i].pc1, vecs[i].i0, vecs[i].i1, vecs[i].ic);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i),  {30'd0, out_valid}, {30'd0, vecs[i].ov});
      chk($sformatf("v%0d_rdy", i), {31'd0, in_ready},  {31'd0, vecs[i].rdy});
      chk($sformatf("v%0d_pc0", i), out_pc0,    vecs[i].opc0);
      chk($sformatf("v%0d_pc1", i), out_pc1,    vecs[i].opc1);
      chk($sformatf("v%0d_i0", i),  out_instr0, vecs[i].oi0);
      chk($sformatf("v%0d_i1", i),  out_instr1, vecs[i].oi1);
    end

    // Reset asserted between edges while a push/pop is pending: clears at once, operation lost.
    @(negedge clk);
    drive(1'b0, 2'b11, 32'h7000, 32'h7004, 32'h2400_0071, 32'h2400_0072, 2'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    @(posedge clk);
    #1;
    chk("rst_after_ov",  {30'd0, out_valid}, 32'd0);
    chk("rst_after_pc0", out_pc0, 32'd0);
    chk("rst_after_i1",  out_instr1, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
